wt_wbuf: RTL
============

WT_WBUF -- requirements
Module: wt_wbuf

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, byte address width.
REQ-002 SHALL have parameter DataWidth, default 32, store word width (8·2^n, 32..128).
REQ-003 SHALL have parameter Depth, default 8, buffer entries (power of two, 2..16).
REQ-004 SHALL have parameter MaxOutstanding, default 7, issued-but-unacked writes (1..15).
REQ-005 SHALL have ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  level drain request.
- req_valid_i / req_ready_o  in/out  1  store handshake.
- req_addr_i  in  AddrWidth  byte address.
- req_data_i  in  DataWidth  store data.
- req_be_i  in  DataWidth/8  byte enables.
- mem_valid_o / mem_ready_i  out/in  1  write-issue handshake.
- mem_addr_o  out  AddrWidth  word-aligned address.
- mem_data_o  out  DataWidth  merged data.
- mem_be_o  out  DataWidth/8  merged enables.
- mem_ack_i  in  1  one write response, one cycle.
- chk_addr_i  in  AddrWidth  load hazard query.
- chk_hit_o  out  1  query word matches any buffered entry (combinational).
- empty_o  out  1  no entries and zero outstanding.

Function
REQ-006 SHALL store entries in a circular FIFO (head/tail pointers, count 0..Depth), addresses word-aligned (low log2(DataWidth/8) bits zeroed).
REQ-007 SHALL assert req_ready_o when (count<Depth or merge possible) and flush not pending.
REQ-008 SHALL merge an accepted store into the youngest entry when its word address matches and that entry is not being issued this cycle: per byte, new byte replaces old where req_be_i set; be ORed; count unchanged.
REQ-009 SHALL otherwise append to tail; a store with req_be_i=0 SHALL be accepted and dropped.
REQ-010 SHALL drive mem_valid_o from head whenever count>0 and outstanding<MaxOutstanding; mem_* SHALL be stable while mem_valid_o high and mem_ready_i low.
REQ-011 SHALL pop head on mem_valid_o&&mem_ready_i and increment outstanding the same edge.
REQ-012 SHALL decrement outstanding on mem_ack_i; simultaneous issue and ack SHALL leave it unchanged; ack at outstanding=0 SHALL be ignored.
REQ-013 SHALL support push and pop in the same cycle at any count, including full (Depth) and count 1 (merge disabled when youngest is head being popped).
REQ-014 SHALL compute chk_hit_o against all valid entries only, ignoring in-flight writes.
REQ-015 SHALL, while flush_i high, deassert req_ready_o and continue draining; flush completion is visible as empty_o=1.
REQ-016 SHALL add zero latency: store accepted at edge N is issuable at cycle N+1 if buffer was empty.

Reset
REQ-017 SHALL, on rst_ni low, asynchronously clear pointers, count, outstanding and valids, regardless of in-flight state.
REQ-018 SHALL reset outputs: req_ready_o=1 (flush_i low), mem_valid_o=0, mem_addr_o/mem_data_o/mem_be_o=0, chk_hit_o=0, empty_o=1.
REQ-019 SHALL not require data storage to be reset.

Structure
REQ-020 SHALL place the entry typedef (addr, data, be, valid) and pointer/count width constants in shared package wt_wbuf_pkg.
REQ-021 SHALL instantiate one sub-module, wt_wbuf_merge, doing combinational byte merge.
REQ-022 SHALL assert Depth power of two and MaxOutstanding>0 at elaboration.

Verification
REQ-023 Reset mid-burst: 5 entries, 3 outstanding, rst_ni low -> empty_o=1, mem_valid_o=0 same cycle.
REQ-024 Merge: store 0x100 data 0x000000AA be 0001 then 0x102 data 0xBB000000 be 1000, mem_ready_i=0 -> one entry, mem_data_o=0xBB0000AA, mem_be_o=1001.
REQ-025 Full: 8 distinct stores, mem_ready_i=0 -> req_ready_o=0; a store to the 8th address still accepted (merge); pop+push same cycle keeps count 8.
REQ-026 Outstanding cap: mem_ready_i=1, no acks -> exactly 7 issues, then mem_valid_o=0; one ack -> one more issue next cycle.
REQ-027 Flush: 3 entries, flush_i=1 -> req_ready_o=0; after 3 issues and 3 acks empty_o=1.
REQ-028 Hazard: entry at 0x200, chk_addr_i=0x203 -> chk_hit_o=1; after issue -> chk_hit_o=0.

Source files
------------

// File: rtl/wt_wbuf_pkg.sv
// Shared types and sizing helpers for the write-through store buffer.
// Entries are held at the widest supported geometry; the top zero-extends into them.
package wt_wbuf_pkg;

  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxDataWidth = 128;
  localparam int unsigned MaxBeWidth   = MaxDataWidth / 8;
  localparam int unsigned OutWidth     = 4;

  typedef struct packed {
    logic                    valid;
    logic [MaxAddrWidth-1:0] addr;
    logic [MaxDataWidth-1:0] data;
    logic [MaxBeWidth-1:0]   be;
  } entry_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/wt_wbuf_merge.sv
// Byte-granular merge of a new store into an existing buffered word.
module wt_wbuf_merge
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic [DataWidth-1:0]   old_data,
  input  logic [DataWidth/8-1:0] old_be,
  input  logic [DataWidth-1:0]   new_data,
  input  logic [DataWidth/8-1:0] new_be,
  output logic [DataWidth-1:0]   data,
  output logic [DataWidth/8-1:0] be
);

  always_comb begin
    data = old_data;
    for (int b = 0; b < int'(DataWidth / 8); b++) begin
      if (new_be[b]) data[b*8 +: 8] = new_data[b*8 +: 8];
    end
  end

  assign be = old_be | new_be;

endmodule

// File: rtl/wt_wbuf.sv
// Write-through store buffer: circular FIFO of word writes with youngest-entry
// merging, an outstanding-write cap, a level flush and a load-hazard query.
module wt_wbuf
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned Depth          = 8,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_be_i,
  output logic                   mem_valid_o,
  input  logic                   mem_ready_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_data_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_ack_i,
  input  logic [AddrWidth-1:0]   chk_addr_i,
  output logic                   chk_hit_o,
  output logic                   empty_o
);

  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned PtrW    = ptr_width(Depth);
  localparam int unsigned CntW    = cnt_width(Depth);
  localparam logic [PtrW-1:0]      LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0]      DepthCnt = CntW'(Depth);
  localparam logic [OutWidth-1:0]  MaxOut   = OutWidth'(MaxOutstanding);
  localparam logic [AddrWidth-1:0] WordMask = ~AddrWidth'(BeWidth - 1);

  if (Depth < 2 || Depth > 16 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "wt_wbuf: Depth must be a power of two in 2..16");
  end
  if (MaxOutstanding < 1 || MaxOutstanding > 15) begin : g_bad_outstanding
    $fatal(1, "wt_wbuf: MaxOutstanding must be in 1..15");
  end
  if (DataWidth < 32 || DataWidth > MaxDataWidth || AddrWidth > MaxAddrWidth) begin : g_bad_width
    $fatal(1, "wt_wbuf: unsupported address/data width");
  end

  entry_t              ent_q [Depth];
  logic [PtrW-1:0]     head_q, tail_q, young;
  logic [CntW-1:0]     count_q;
  logic [OutWidth-1:0] outst_q;

  logic [AddrWidth-1:0] req_word, chk_word;
  logic                 issue, merge_ok, accept, do_merge, do_push, ack_eff;
  logic [DataWidth-1:0] merged_data;
  logic [BeWidth-1:0]   merged_be;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign req_word = req_addr_i & WordMask;
  assign chk_word = chk_addr_i & WordMask;
  assign young    = (tail_q == '0) ? LastPtr : tail_q - 1'b1;

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the initiator holds its payload stable
  // until then, and ready may depend combinationally on the other side.
  assign mem_valid_o = (count_q != '0) && (outst_q < MaxOut);
  assign issue       = mem_valid_o && mem_ready_i;

  // The youngest entry is the head only at count 1; never merge into a word leaving now.
  assign merge_ok = (count_q != '0)
                 && (ent_q[young].addr == MaxAddrWidth'(req_word))
                 && !(issue && count_q == CntW'(1));

  // A pop this cycle frees the slot a push at full would need.
  assign req_ready_o = !flush_i && ((count_q < DepthCnt) || issue || merge_ok);
  assign accept      = req_valid_i && req_ready_o;
  assign do_merge    = accept && (req_be_i != '0) && merge_ok;
  assign do_push     = accept && (req_be_i != '0) && !merge_ok;
  assign ack_eff     = mem_ack_i && (outst_q != '0);

  wt_wbuf_merge #(.DataWidth(DataWidth)) u_merge (
    .old_data (ent_q[young].data[DataWidth-1:0]),
    .old_be   (ent_q[young].be[BeWidth-1:0]),
    .new_data (req_data_i),
    .new_be   (req_be_i),
    .data     (merged_data),
    .be       (merged_be)
  );

  assign mem_addr_o = mem_valid_o ? ent_q[head_q].addr[AddrWidth-1:0] : '0;
  assign mem_data_o = mem_valid_o ? ent_q[head_q].data[DataWidth-1:0] : '0;
  assign mem_be_o   = mem_valid_o ? ent_q[head_q].be[BeWidth-1:0]     : '0;
  assign empty_o    = (count_q == '0) && (outst_q == '0);

  always_comb begin
    chk_hit_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (ent_q[i].valid && ent_q[i].addr == MaxAddrWidth'(chk_word)) chk_hit_o = 1'b1;
    end
  end

  // Only valids are reset; payload fields are qualified by them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      outst_q <= '0;
      for (int i = 0; i < int'(Depth); i++) ent_q[i].valid <= 1'b0;
    end else begin
      if (issue) begin
        ent_q[head_q].valid <= 1'b0;
        head_q              <= next_ptr(head_q);
      end
      if (do_merge) begin
        ent_q[young].data <= MaxDataWidth'(merged_data);
        ent_q[young].be   <= MaxBeWidth'(merged_be);
      end
      // At full the tail slot equals the head being popped; this write wins.
      if (do_push) begin
        ent_q[tail_q] <= '{valid: 1'b1,
                           addr:  MaxAddrWidth'(req_word),
                           data:  MaxDataWidth'(req_data_i),
                           be:    MaxBeWidth'(req_be_i)};
        tail_q <= next_ptr(tail_q);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(issue);
      if (issue && !ack_eff)      outst_q <= outst_q + 1'b1;
      else if (!issue && ack_eff) outst_q <= outst_q - 1'b1;
    end
  end

endmodule
